// File: rtl/t_frame_buffer_pkg.sv
// Shared sizing and capture-state encoding for the T(0,i) ping-pong frame store.
package t_pkg;

    localparam int BIT_WIDTH = 32;
    localparam int I         = 160;
    localparam int NU_VALUES = 3;
    localparam int ADDR_W    = $clog2(I);

    typedef enum logic {
        IDLE,
        CAPTURE
    } cap_state_t;

endpackage

// File: rtl/t_frame_buffer_bank.sv
// One bank of the frame store: simple dual-port RAM, one write port, one registered read port.
module t_bank_ram #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 160,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST)) begin
            mem[waddr] <= wdata;
        end
        if (raddr <= LAST) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/t_frame_buffer.sv
// Ping-pong frame store: captures I sequential nu-triples with per-nu peak tracking,
// then swaps banks so the finished frame can be randomly read while the next one fills.
module t_frame_buffer #(
    parameter int BIT_WIDTH = t_pkg::BIT_WIDTH,
    parameter int I         = t_pkg::I,
    parameter int NU_VALUES = t_pkg::NU_VALUES,
    parameter int ADDR_W    = $clog2(I)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        in_valid,
    input  logic [ADDR_W-1:0]           in_address,
    input  logic signed [BIT_WIDTH-1:0] in_data_0,
    input  logic signed [BIT_WIDTH-1:0] in_data_1,
    input  logic signed [BIT_WIDTH-1:0] in_data_2,
    input  logic [1:0]                  rd_nu,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic signed [BIT_WIDTH-1:0] rd_data,
    output logic                        frame_ready,
    input  logic                        frame_release,
    output logic signed [BIT_WIDTH-1:0] peak_value_0,
    output logic signed [BIT_WIDTH-1:0] peak_value_1,
    output logic signed [BIT_WIDTH-1:0] peak_value_2,
    output logic [ADDR_W-1:0]           peak_index_0,
    output logic [ADDR_W-1:0]           peak_index_1,
    output logic [ADDR_W-1:0]           peak_index_2,
    output logic                        overrun,
    output logic                        abort
);
    import t_pkg::*;

    localparam int                WORD_W    = NU_VALUES * BIT_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(I - 1);

    function automatic logic is_greater(input logic signed [BIT_WIDTH-1:0] a,
                                        input logic signed [BIT_WIDTH-1:0] b);
        return a > b;
    endfunction

    cap_state_t        state, state_next;
    logic [ADDR_W-1:0] exp_addr;
    logic              start, wr_en, complete, abort_set;
    logic              bank_sel, pending;
    logic              do_swap, set_pending, drop_ready, overrun_set;

    logic signed [BIT_WIDTH-1:0] sample       [NU_VALUES];
    logic signed [BIT_WIDTH-1:0] trk_val      [NU_VALUES];
    logic signed [BIT_WIDTH-1:0] trk_val_next [NU_VALUES];
    logic [ADDR_W-1:0]           trk_idx      [NU_VALUES];
    logic [ADDR_W-1:0]           trk_idx_next [NU_VALUES];

    assign sample[0] = in_data_0;
    assign sample[1] = in_data_1;
    assign sample[2] = in_data_2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        wr_en      = 1'b0;
        complete   = 1'b0;
        abort_set  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && (in_address == '0)) begin
                    start      = 1'b1;
                    wr_en      = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!in_valid) begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end else if (in_address == exp_addr) begin
                    wr_en = 1'b1;
                    if (in_address == LAST_ADDR) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (in_address == '0) begin
                    // Out-of-order restart: drop the partial frame and begin again at entry 0.
                    abort_set = 1'b1;
                    start     = 1'b1;
                    wr_en     = 1'b1;
                end else begin
                    abort_set  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new frame while one is pending discards the pending one, even if released the same cycle.
    always_comb begin
        do_swap     = 1'b0;
        set_pending = 1'b0;
        drop_ready  = 1'b0;
        overrun_set = start && pending;
        if (complete) begin
            if (!frame_ready || frame_release) begin
                do_swap = 1'b1;
            end else begin
                set_pending = 1'b1;
            end
        end else if (frame_release && frame_ready) begin
            if (pending && !overrun_set) begin
                do_swap = 1'b1;
            end else begin
                drop_ready = 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NU_VALUES; k++) begin
            trk_val_next[k] = trk_val[k];
            trk_idx_next[k] = trk_idx[k];
            if (start) begin
                trk_val_next[k] = sample[k];
                trk_idx_next[k] = '0;
            end else if (wr_en && is_greater(sample[k], trk_val[k])) begin
                trk_val_next[k] = sample[k];
                trk_idx_next[k] = in_address;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            exp_addr <= in_address + ADDR_W'(1);
        end
        for (int k = 0; k < NU_VALUES; k++) begin
            trk_val[k] <= trk_val_next[k];
            trk_idx[k] <= trk_idx_next[k];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bank_sel     <= 1'b0;
            pending      <= 1'b0;
            frame_ready  <= 1'b0;
            overrun      <= 1'b0;
            abort        <= 1'b0;
            peak_value_0 <= '0;
            peak_value_1 <= '0;
            peak_value_2 <= '0;
            peak_index_0 <= '0;
            peak_index_1 <= '0;
            peak_index_2 <= '0;
        end else begin
            abort   <= abort_set;
            overrun <= overrun_set;
            if (do_swap) begin
                bank_sel     <= ~bank_sel;
                frame_ready  <= 1'b1;
                peak_value_0 <= trk_val_next[0];
                peak_value_1 <= trk_val_next[1];
                peak_value_2 <= trk_val_next[2];
                peak_index_0 <= trk_idx_next[0];
                peak_index_1 <= trk_idx_next[1];
                peak_index_2 <= trk_idx_next[2];
            end else if (drop_ready) begin
                frame_ready <= 1'b0;
            end
            if (set_pending) begin
                pending <= 1'b1;
            end else if (do_swap || overrun_set) begin
                pending <= 1'b0;
            end
        end
    end

    // bank_sel names the read bank; the other bank takes capture writes.
    logic [WORD_W-1:0] wdata, q0, q1;
    assign wdata = {in_data_2, in_data_1, in_data_0};

    t_bank_ram #(.WIDTH(WORD_W), .DEPTH(I), .AW(ADDR_W)) u_bank0 (
        .clk   (clk_in),
        .we    (wr_en && bank_sel),
        .waddr (in_address),
        .wdata (wdata),
        .raddr (rd_addr),
        .rdata (q0)
    );

    t_bank_ram #(.WIDTH(WORD_W), .DEPTH(I), .AW(ADDR_W)) u_bank1 (
        .clk   (clk_in),
        .we    (wr_en && !bank_sel),
        .waddr (in_address),
        .wdata (wdata),
        .raddr (rd_addr),
        .rdata (q1)
    );

    // Stage p1: read select registered alongside the RAM read
    logic [1:0]        rd_nu_p1;
    logic              sel_p1, zero_p1;
    logic [WORD_W-1:0] word_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_nu_p1 <= '0;
            sel_p1   <= 1'b0;
            zero_p1  <= 1'b1;
        end else begin
            rd_nu_p1 <= rd_nu;
            sel_p1   <= bank_sel;
            zero_p1  <= (rd_nu == 2'd3) || (rd_addr > LAST_ADDR);
        end
    end

    always_comb begin
        word_p1 = sel_p1 ? q1 : q0;
        rd_data = '0;
        if (!zero_p1) begin
            case (rd_nu_p1)
                2'd0:    rd_data = word_p1[0 +: BIT_WIDTH];
                2'd1:    rd_data = word_p1[BIT_WIDTH +: BIT_WIDTH];
                2'd2:    rd_data = word_p1[2*BIT_WIDTH +: BIT_WIDTH];
                default: rd_data = '0;
            endcase
        end
    end

endmodule
